// File: rtl/execute_sequencer_if.sv
`timescale 1ns/1ps
// Bundle of execute-stage signals between the sequencer and its neighbours
// (decode, ALU, multiplier, divider, memory stage).
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high. Valid may not depend on ready, and once raised it holds its
// payload stable until that transfer edge. The in_* pair carries instructions
// from decode; the out_* pair carries results to the memory stage.
interface execute_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [1:0]  in_op_class;
    logic        in_branch_taken;
    logic [63:0] in_target;
    logic [63:0] alu_result;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_done;
    logic [63:0] div_result;
    logic        div_abort;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [63:0] out_pc;
    logic        jump_enable;
    logic [63:0] jump_target;
    logic        execute_done;
    logic        timeout_err;

    // Surrounding pipeline and functional units.
    modport master (
        output in_valid, in_pc, in_op_class, in_branch_taken, in_target,
        output alu_result, mul_result, div_done, div_result, flush, out_ready,
        input  in_ready, div_start, div_abort, out_valid, out_data, out_pc,
        input  jump_enable, jump_target, execute_done, timeout_err
    );

    // The execute sequencer.
    modport slave (
        input  in_valid, in_pc, in_op_class, in_branch_taken, in_target,
        input  alu_result, mul_result, div_done, div_result, flush, out_ready,
        output in_ready, div_start, div_abort, out_valid, out_data, out_pc,
        output jump_enable, jump_target, execute_done, timeout_err
    );
endinterface

// File: rtl/execute_sequencer.sv
`timescale 1ns/1ps
// Execute-stage control FSM: accepts one instruction at a time, completes
// ALU/branch ops in one cycle, waits a fixed latency for MUL, runs DIV on the
// iterative divider with a timeout, and holds the result until the memory
// stage takes it.
module execute_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_TIMEOUT = 70
) (
    input  logic                 clk,
    input  logic                 reset,
    execute_sequencer_if.slave   bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    // One shared counter: MUL latency countdown or DIV timeout count-up.
    localparam int CNT_MAX = (MUL_LATENCY > DIV_TIMEOUT) ? MUL_LATENCY : DIV_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_LOAD  = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LIMIT = CW'(DIV_TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [63:0]   out_data_q;
    logic [63:0]   out_pc_q;
    logic          jump_en_q;
    logic [63:0]   jump_target_q;
    logic          timeout_err_q;

    logic          in_ready_c;
    logic          accept;
    logic          out_valid_c;
    logic          execute_done_c;
    logic          div_start_c;
    logic          div_abort_c;
    logic          div_timeout;

    // run_q keeps in_ready low while reset is held and for the first edge
    // after release, so every output reads 0 during reset.
    assign accept      = bus.in_valid && in_ready_c;
    assign div_timeout = (state_q == DIV_WAIT) && !bus.div_done && (cnt_q == DIV_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        case (bus.in_op_class)
                            OP_ALU, OP_BR: state_d = HOLD;
                            OP_MUL:        state_d = MUL_WAIT;
                            default:       state_d = DIV_WAIT;
                        endcase
                    end else if (state_q == HOLD && bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                MUL_WAIT: if (cnt_q == '0) state_d = HOLD;
                DIV_WAIT: if (bus.div_done || cnt_q == DIV_LIMIT) state_d = HOLD;
                default:  state_d = IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_ready_c     = run_q && !bus.flush &&
                         (state_q == IDLE || (state_q == HOLD && bus.out_ready));
        out_valid_c    = (state_q == HOLD);
        execute_done_c = (state_q == HOLD) && bus.out_ready && !bus.flush;
        // cnt_q is 0 only in the first DIV_WAIT cycle since it counts upward.
        div_start_c    = (state_q == DIV_WAIT) && (cnt_q == '0);
        div_abort_c    = (state_q == DIV_WAIT) && (bus.flush || div_timeout);
    end

    // Result/PC capture, counter, jump redirect pulse and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q         <= 1'b0;
            cnt_q         <= '0;
            out_data_q    <= '0;
            out_pc_q      <= '0;
            jump_en_q     <= 1'b0;
            jump_target_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            jump_en_q <= 1'b0;
            if (accept) begin
                out_pc_q <= bus.in_pc;
                case (bus.in_op_class)
                    OP_ALU: out_data_q <= bus.alu_result;
                    OP_BR: begin
                        out_data_q <= bus.in_pc + 64'd4;
                        if (bus.in_branch_taken) begin
                            jump_en_q     <= 1'b1;
                            jump_target_q <= bus.in_target;
                        end
                    end
                    OP_MUL:  cnt_q <= MUL_LOAD;
                    default: cnt_q <= '0;
                endcase
            end else if (!bus.flush && state_q == MUL_WAIT) begin
                if (cnt_q == '0) out_data_q <= bus.mul_result;
                else             cnt_q      <= cnt_q - CW'(1);
            end else if (!bus.flush && state_q == DIV_WAIT) begin
                if (bus.div_done) begin
                    out_data_q <= bus.div_result;
                end else if (cnt_q == DIV_LIMIT) begin
                    out_data_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
                    timeout_err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.execute_done = execute_done_c;
    assign bus.div_start    = div_start_c;
    assign bus.div_abort    = div_abort_c;
    assign bus.out_data     = out_data_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.jump_enable  = jump_en_q;
    assign bus.jump_target  = jump_target_q;
    assign bus.timeout_err  = timeout_err_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_execute_sequencer.sv
`timescale 1ns/1ps
// Directed bench for execute_sequencer with MUL_LATENCY=3, DIV_TIMEOUT=4.
module tb_execute_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  state_dbg;
    int          checks;
    int          errors;
    int          done_cnt;
    logic [127:0] exp_q[$];   // {out_pc, out_data} of each result expected to retire

    execute_sequencer_if bus();

    execute_sequencer #(.MUL_LATENCY(3), .DIV_TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every execute_done must retire the oldest expected result.
    always @(negedge clk) begin
        if (bus.execute_done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", bus.execute_done, 64'd0);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                check("sb_pc", bus.out_pc, e[127:64]);
                check("sb_data", bus.out_data, e[63:0]);
                check("sb_valid", bus.out_valid, 64'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [63:0] pc, input logic taken,
                         input logic [63:0] target, input logic [63:0] alu);
        bus.in_valid        = 1'b1;
        bus.in_op_class     = op;
        bus.in_pc           = pc;
        bus.in_branch_taken = taken;
        bus.in_target       = target;
        bus.alu_result      = alu;
    endtask

    // Wait (bounded) until in_ready is seen at a negedge, then take the edge.
    task automatic accept_now();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) seen = 1'b1;
        end
        check("in_ready_wait", seen, 64'd1);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset    = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_op_class = 2'b00;
        bus.in_branch_taken = 1'b0; bus.in_target = '0; bus.alu_result = '0;
        bus.mul_result = '0; bus.div_done = 1'b0; bus.div_result = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_in_ready", bus.in_ready, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_timeout_err", bus.timeout_err, 64'd0);
        check("rst_state", state_dbg, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // ALU back-to-back with in_valid held high.
        bus.out_ready = 1'b1;
        offer(2'b00, 64'h100, 1'b0, 64'h0, 64'd5);
        exp_q.push_back({64'h100, 64'd5});
        @(negedge clk);
        check("alu_in_ready_idle", bus.in_ready, 64'd1);
        cyc();
        offer(2'b00, 64'h104, 1'b0, 64'h0, 64'd9);
        exp_q.push_back({64'h104, 64'd9});
        @(negedge clk);
        check("alu1_valid", bus.out_valid, 64'd1);
        check("alu1_data", bus.out_data, 64'd5);
        check("alu1_pc", bus.out_pc, 64'h100);
        check("alu1_in_ready", bus.in_ready, 64'd1);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("alu2_valid", bus.out_valid, 64'd1);
        check("alu2_data", bus.out_data, 64'd9);
        check("alu2_pc", bus.out_pc, 64'h104);
        cyc();
        @(negedge clk);
        check("alu_idle_valid", bus.out_valid, 64'd0);
        check("alu_done_count", done_cnt, 64'd2);

        // Taken JAL, then not-taken branch.
        cyc();
        offer(2'b01, 64'h2000, 1'b1, 64'h2400, 64'h0);
        exp_q.push_back({64'h2000, 64'h2004});
        accept_now();
        @(negedge clk);
        check("jal_jump_en", bus.jump_enable, 64'd1);
        check("jal_target", bus.jump_target, 64'h2400);
        check("jal_link", bus.out_data, 64'h2004);
        cyc();
        @(negedge clk);
        check("jal_jump_pulse_end", bus.jump_enable, 64'd0);
        cyc();
        offer(2'b01, 64'h3000, 1'b0, 64'h3400, 64'h0);
        exp_q.push_back({64'h3000, 64'h3004});
        accept_now();
        @(negedge clk);
        check("br_nt_jump_en", bus.jump_enable, 64'd0);
        check("br_nt_link", bus.out_data, 64'h3004);
        cyc();

        // MUL latency, then stall under backpressure.
        bus.out_ready  = 1'b0;
        bus.mul_result = 64'd7;
        offer(2'b10, 64'h400, 1'b0, 64'h0, 64'h0);
        exp_q.push_back({64'h400, 64'd42});
        accept_now();                       // now in cycle t+1
        @(negedge clk);
        check("mul_t1_valid", bus.out_valid, 64'd0);
        check("mul_t1_in_ready", bus.in_ready, 64'd0);
        check("mul_t1_jump_en", bus.jump_enable, 64'd0);
        cyc();
        @(negedge clk);
        check("mul_t2_valid", bus.out_valid, 64'd0);
        cyc();
        bus.mul_result = 64'd42;            // cycle t+3
        @(negedge clk);
        check("mul_t3_valid", bus.out_valid, 64'd0);
        check("mul_t3_in_ready", bus.in_ready, 64'd0);
        cyc();
        bus.mul_result = 64'hDEAD;          // cycle t+4
        @(negedge clk);
        check("mul_t4_valid", bus.out_valid, 64'd1);
        check("mul_t4_data", bus.out_data, 64'd42);
        check("mul_t4_in_ready", bus.in_ready, 64'd0);
        cyc();
        @(negedge clk);
        check("mul_stall_data", bus.out_data, 64'd42);
        check("mul_stall_in_ready", bus.in_ready, 64'd0);
        check("mul_stall_done", bus.execute_done, 64'd0);
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mul_release_in_ready", bus.in_ready, 64'd1);
        cyc();
        bus.out_ready = 1'b0;

        // DIV timeout.
        offer(2'b11, 64'h500, 1'b0, 64'h0, 64'h0);
        exp_q.push_back({64'h500, 64'hFFFF_FFFF_FFFF_FFFF});
        accept_now();
        @(negedge clk);
        check("div_start_t1", bus.div_start, 64'd1);
        check("div_abort_t1", bus.div_abort, 64'd0);
        cyc();
        @(negedge clk);
        check("div_start_t2", bus.div_start, 64'd0);
        cyc();
        cyc();
        @(negedge clk);
        check("div_abort_t4", bus.div_abort, 64'd1);
        check("div_valid_t4", bus.out_valid, 64'd0);
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("div_abort_t5", bus.div_abort, 64'd0);
        check("div_timeout_err", bus.timeout_err, 64'd1);
        check("div_to_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        bus.out_ready = 1'b0;

        // DIV with div_done on the timeout cycle.
        bus.div_result = 64'h77;
        offer(2'b11, 64'h600, 1'b0, 64'h0, 64'h0);
        exp_q.push_back({64'h600, 64'h77});
        accept_now();
        cyc();
        cyc();
        cyc();
        bus.div_done = 1'b1;                // cycle t+4
        @(negedge clk);
        check("div_race_abort", bus.div_abort, 64'd0);
        cyc();
        bus.div_done  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("div_race_valid", bus.out_valid, 64'd1);
        check("div_race_data", bus.out_data, 64'h77);
        check("div_err_sticky", bus.timeout_err, 64'd1);
        cyc();
        bus.out_ready = 1'b0;

        // Flush in DIV_WAIT.
        offer(2'b11, 64'h700, 1'b0, 64'h0, 64'h0);
        accept_now();
        cyc();
        bus.flush = 1'b1;
        @(negedge clk);
        check("fl_div_abort", bus.div_abort, 64'd1);
        check("fl_div_in_ready", bus.in_ready, 64'd0);
        cyc();
        bus.flush = 1'b0;
        @(negedge clk);
        check("fl_div_state", state_dbg, 64'd0);
        check("fl_div_valid", bus.out_valid, 64'd0);
        check("fl_div_abort_end", bus.div_abort, 64'd0);
        cyc();

        // Flush in HOLD with out_ready high and a new instruction offered.
        offer(2'b00, 64'h800, 1'b0, 64'h0, 64'h55);
        accept_now();
        @(negedge clk);
        check("fl_hold_valid", bus.out_valid, 64'd1);
        cyc();
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        offer(2'b00, 64'h804, 1'b0, 64'h0, 64'h66);
        @(negedge clk);
        check("fl_hold_done", bus.execute_done, 64'd0);
        check("fl_hold_in_ready", bus.in_ready, 64'd0);
        cyc();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("fl_hold_state", state_dbg, 64'd0);
        check("fl_hold_valid_drop", bus.out_valid, 64'd0);
        cyc();

        // Asynchronous reset in MUL_WAIT.
        bus.out_ready = 1'b1;
        offer(2'b10, 64'h900, 1'b0, 64'h0, 64'h0);
        accept_now();
        #2;
        reset = 1'b0;
        #1;
        check("arst_state", state_dbg, 64'd0);
        check("arst_valid", bus.out_valid, 64'd0);
        check("arst_in_ready", bus.in_ready, 64'd0);
        check("arst_out_pc", bus.out_pc, 64'd0);
        check("arst_jump_target", bus.jump_target, 64'd0);
        check("arst_timeout_err", bus.timeout_err, 64'd0);
        check("arst_div_abort", bus.div_abort, 64'd0);
        #2;
        reset = 1'b1;
        cyc();
        offer(2'b00, 64'hA00, 1'b0, 64'h0, 64'h1234);
        exp_q.push_back({64'hA00, 64'h1234});
        accept_now();
        @(negedge clk);
        check("arst_alu_valid", bus.out_valid, 64'd1);
        check("arst_alu_data", bus.out_data, 64'h1234);
        cyc();
        bus.out_ready = 1'b0;
        cyc();

        check("sb_queue_empty", exp_q.size(), 64'd0);
        check("total_done_count", done_cnt, 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
